// File: rtl/wormhole_port_scheduler_pkg.sv
// wormhole_port_scheduler_pkg: flit types, port indices and scheduler states
package wormhole_port_scheduler_pkg;
  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY = 3'b010;
  localparam logic [2:0] FLIT_TAIL = 3'b100;
  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_S = 4;
  typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/wormhole_port_scheduler_rr_pick5.sv
// rr_pick5: combinational round-robin pick of the first eligible input after i_ptr
module rr_pick5 #(
  parameter int N = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_win,
  output logic          o_found
);
  logic [PW-1:0] w_i;
  // scan ptr+1, ptr+2, ... modulo N and keep the first hit
  always_comb begin
    o_win = '0;
    o_found = 1'b0;
    w_i = '0;
    for (int k = 1; k <= N; k++) begin
      w_i = PW'((int'(i_ptr) + k) % N);
      if (!o_found && i_elig[w_i]) begin
        o_win[w_i] = 1'b1;
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wormhole_port_scheduler.sv
// wormhole_port_scheduler: per-output wormhole lock with round-robin header arbitration; optional WORMHOLE_TIMEOUT_EN forces release after a stall
module wormhole_port_scheduler
  import wormhole_port_scheduler_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int LEN_W = 12,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       req_i,
  input  logic [3*NUM_PORTS-1:0]     flit_id_i,
  input  logic [LEN_W*NUM_PORTS-1:0] length_i,
  input  logic                       out_ready_i,
  output logic [NUM_PORTS-1:0]       grant_o,
  output logic [NUM_PORTS-1:0]       sel_o,
  output logic                       busy_o,
  output logic [LEN_W-1:0]           flits_left_o,
  output logic                       timeout_o
);
  localparam int PW = $clog2(NUM_PORTS);
  state_t r_state;
  logic [PW-1:0] r_owner, r_rr, w_idx;
  logic [LEN_W-1:0] r_cnt, w_len;
  logic [NUM_PORTS-1:0] w_elig, w_win;
  logic w_found, w_fire, w_expire;
  // only header flits may compete; note the winner's index and length
  always_comb begin
    w_elig = '0;
    w_idx = '0;
    w_len = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_elig[i] = req_i[i] && flit_id_i[3*i +: 3] == FLIT_HEADER;
      if (w_win[i]) begin
        w_idx = PW'(i);
        w_len = length_i[LEN_W*i +: LEN_W];
      end
    end
  end
  rr_pick5 #(.N(NUM_PORTS)) u_pick (
    .i_elig(w_elig),
    .i_ptr(r_rr),
    .o_win(w_win),
    .o_found(w_found)
  );
  assign w_fire = r_state == ACTIVE && req_i[r_owner] && out_ready_i;
  assign grant_o = w_fire ? NUM_PORTS'(1) << r_owner : '0;
  assign sel_o = r_state == ACTIVE ? NUM_PORTS'(1) << r_owner : '0;
  assign busy_o = r_state == ACTIVE;
  assign flits_left_o = r_cnt;
`ifdef WORMHOLE_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] r_stall;
  logic r_to;
  assign w_expire = r_state == ACTIVE && !w_fire && r_stall == SW'(TIMEOUT - 1);
  assign timeout_o = r_to;
  // count consecutive grantless locked cycles and pulse on forced release
  always_ff @(posedge clk) begin
    r_stall <= (rst || r_state == IDLE || w_fire || w_expire) ? '0 : r_stall + 1'b1;
    r_to <= !rst && w_expire;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign w_expire = 1'b0;
  assign timeout_o = 1'b0;
`endif
  // lock on a winning header, count flits down, release on last flit or expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_rr <= PW'(NUM_PORTS - 1);
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_found) begin
        r_owner <= w_idx;
        r_cnt <= w_len == '0 ? LEN_W'(1) : w_len;
        r_state <= ACTIVE;
      end
    end else if (w_fire) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == LEN_W'(1)) begin
        r_state <= IDLE;
        r_rr <= r_owner;
      end
    end else if (w_expire) begin
      r_state <= IDLE;
      r_rr <= r_owner;
      r_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_wormhole_port_scheduler.sv
// tb_wormhole_port_scheduler: directed vector table plus corner-case sequences
module tb_wormhole_port_scheduler;
  import wormhole_port_scheduler_pkg::*;
  localparam logic [2:0] H = FLIT_HEADER;
  localparam logic [2:0] B = FLIT_BODY;
  localparam logic [2:0] T = FLIT_TAIL;
  localparam logic [2:0] Z = 3'b000;
  typedef struct {
    logic [4:0] req;
    logic [14:0] fid;
    logic [59:0] len;
    logic rdy;
    logic [4:0] g;
    logic [4:0] s;
    logic b;
    logic [11:0] left;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] req = '0;
  logic [14:0] fid = '0;
  logic [59:0] len = '0;
  logic rdy = 1'b0;
  logic [4:0] grant, sel;
  logic busy, tmo;
  logic [11:0] left;
  int total = 0;
  int bad = 0;
  vec_t tv[$];
  always #5 clk = ~clk;
  wormhole_port_scheduler #(.NUM_PORTS(5), .LEN_W(12), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .flit_id_i(fid),
    .length_i(len),
    .out_ready_i(rdy),
    .grant_o(grant),
    .sel_o(sel),
    .busy_o(busy),
    .flits_left_o(left),
    .timeout_o(tmo)
  );
  function automatic logic [14:0] fid5(input logic [2:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction
  function automatic logic [59:0] lenp(input int p, input logic [11:0] v);
    logic [59:0] r = '0;
    r[12*p +: 12] = v;
    return r;
  endfunction
  function automatic vec_t mk(input logic [4:0] rq, input logic [14:0] f, input logic [59:0] l,
                              input logic rd, input logic [4:0] g, input logic [4:0] s,
                              input logic b, input logic [11:0] lf);
    vec_t v;
    v.req = rq; v.fid = f; v.len = l; v.rdy = rd; v.g = g; v.s = s; v.b = b; v.left = lf;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  initial begin
    // L length 3: lock, then three grants
    tv.push_back(mk(5'b00001, fid5(H, Z, Z, Z, Z), lenp(0, 3), 1, 5'b00000, 5'b00000, 0, 0));
    tv.push_back(mk(5'b00001, fid5(H, Z, Z, Z, Z), lenp(0, 3), 1, 5'b00001, 5'b00001, 1, 3));
    tv.push_back(mk(5'b00001, fid5(B, Z, Z, Z, Z), '0, 1, 5'b00001, 5'b00001, 1, 2));
    tv.push_back(mk(5'b00001, fid5(T, Z, Z, Z, Z), '0, 1, 5'b00001, 5'b00001, 1, 1));
    tv.push_back(mk(5'b00000, '0, '0, 1, 5'b00000, 5'b00000, 0, 0));
    // N length 4 with stalls; S header waits
    tv.push_back(mk(5'b00010, fid5(Z, H, Z, Z, Z), lenp(1, 4), 1, 5'b00000, 5'b00000, 0, 0));
    tv.push_back(mk(5'b00010, fid5(Z, H, Z, Z, Z), lenp(1, 4), 1, 5'b00010, 5'b00010, 1, 4));
    tv.push_back(mk(5'b00010, fid5(Z, B, Z, Z, Z), '0, 1, 5'b00010, 5'b00010, 1, 3));
    tv.push_back(mk(5'b10010, fid5(Z, B, Z, Z, H), lenp(4, 2), 0, 5'b00000, 5'b00010, 1, 2));
    tv.push_back(mk(5'b10010, fid5(Z, B, Z, Z, H), lenp(4, 2), 0, 5'b00000, 5'b00010, 1, 2));
    tv.push_back(mk(5'b10000, fid5(Z, B, Z, Z, H), lenp(4, 2), 1, 5'b00000, 5'b00010, 1, 2));
    tv.push_back(mk(5'b10010, fid5(Z, B, Z, Z, H), lenp(4, 2), 1, 5'b00010, 5'b00010, 1, 2));
    tv.push_back(mk(5'b10010, fid5(Z, T, Z, Z, H), lenp(4, 2), 1, 5'b00010, 5'b00010, 1, 1));
    tv.push_back(mk(5'b10000, fid5(Z, Z, Z, Z, H), lenp(4, 2), 1, 5'b00000, 5'b00000, 0, 0));
    tv.push_back(mk(5'b10000, fid5(Z, Z, Z, Z, H), lenp(4, 2), 1, 5'b10000, 5'b10000, 1, 2));
    tv.push_back(mk(5'b10000, fid5(Z, Z, Z, Z, T), '0, 1, 5'b10000, 5'b10000, 1, 1));
    // body flit at head never wins
    tv.push_back(mk(5'b00001, fid5(B, Z, Z, Z, Z), lenp(0, 5), 1, 5'b00000, 5'b00000, 0, 0));
    tv.push_back(mk(5'b00001, fid5(B, Z, Z, Z, Z), lenp(0, 5), 1, 5'b00000, 5'b00000, 0, 0));
    // length 0 is treated as a single flit
    tv.push_back(mk(5'b00001, fid5(H, Z, Z, Z, Z), lenp(0, 0), 1, 5'b00000, 5'b00000, 0, 0));
    tv.push_back(mk(5'b00001, fid5(H, Z, Z, Z, Z), lenp(0, 0), 1, 5'b00001, 5'b00001, 1, 1));
    tv.push_back(mk(5'b00000, '0, '0, 1, 5'b00000, 5'b00000, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset grant", 32'(grant), 0);
    chk("reset sel", 32'(sel), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset left", 32'(left), 0);
    chk("reset timeout", 32'(tmo), 0);
    foreach (tv[i]) begin
      req = tv[i].req; fid = tv[i].fid; len = tv[i].len; rdy = tv[i].rdy;
      #1;
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(tv[i].g));
      chk($sformatf("v%0d sel", i), 32'(sel), 32'(tv[i].s));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].b));
      chk($sformatf("v%0d left", i), 32'(left), 32'(tv[i].left));
      @(negedge clk);
    end
    // L and E single-flit headers: rr pointer sits at L, so E goes first, then alternate
    req = 5'b00101; fid = fid5(H, Z, H, Z, Z); len = lenp(0, 1) | lenp(2, 1); rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("alt%0d grant", k), 32'(grant),
          (k % 2 == 0) ? 0 : (((k / 2) % 2 == 0) ? 32'b00100 : 32'b00001));
      chk($sformatf("alt%0d busy", k), 32'(busy), 32'(k % 2));
      @(negedge clk);
    end
    // reset in the middle of a packet
    req = 5'b00001; fid = fid5(H, Z, Z, Z, Z); len = lenp(0, 5);
    @(negedge clk);
    #1;
    chk("mid grant", 32'(grant), 32'b00001);
    chk("mid left", 32'(left), 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = '0; fid = '0; len = '0;
    #1;
    chk("mid-rst busy", 32'(busy), 0);
    chk("mid-rst left", 32'(left), 0);
    chk("mid-rst sel", 32'(sel), 0);
    @(negedge clk);
`ifdef WORMHOLE_TIMEOUT_EN
    // W stalls for 8 cycles, lock is forced off and waiting E wins
    req = 5'b01000; fid = fid5(Z, Z, Z, H, Z); len = lenp(3, 3); rdy = 1'b0;
    #1;
    chk("to idle busy", 32'(busy), 0);
    @(negedge clk);
    req = 5'b01100; fid = fid5(Z, Z, H, H, Z); len = lenp(3, 3) | lenp(2, 2);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("stall%0d busy", k), 32'(busy), 1);
      chk($sformatf("stall%0d timeout", k), 32'(tmo), 0);
      @(negedge clk);
    end
    #1;
    chk("to pulse", 32'(tmo), 1);
    chk("to released", 32'(busy), 0);
    @(negedge clk);
    rdy = 1'b1;
    #1;
    chk("to next grant", 32'(grant), 32'b00100);
    chk("to pulse end", 32'(tmo), 0);
    @(negedge clk);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wormhole_port_scheduler.md
Name: wormhole_port_scheduler

Overview:
Per-output-port scheduler for the 5-port mesh router. Inputs L, N, E, W and S request the output port. One input wins by round-robin on a header flit, and the port stays locked to it until the packet's full flit count has been transferred (wormhole switching). It drives the input-FIFO read grants and the one-hot crossbar select for its port. It is instantiated five times per router, one per output port.

Parameters:
NUM_PORTS, 5, number of requesting inputs; index order 0=L, 1=N, 2=E, 3=W, 4=S
LEN_W, 12, width of the packet-length field
TIMEOUT, 1023, stall cycles before a forced lock release (used only with the optional feature)

Ports:
clk  input  1  clock
rst  input  1  reset
req_i  input  NUM_PORTS  input i has a flit at its FIFO head routed to this port
flit_id_i  input  3*NUM_PORTS  flit type of each FIFO head; slice i is [3*i+2:3*i]
length_i  input  LEN_W*NUM_PORTS  packet length in flits, header included; valid on header flits
out_ready_i  input  1  downstream ready for this output port
grant_o  output  NUM_PORTS  one-hot; pops owner FIFO and transfers one flit this cycle
sel_o  output  NUM_PORTS  one-hot crossbar select; equals owner while ACTIVE, else 0
busy_o  output  1  port locked (ACTIVE)
flits_left_o  output  LEN_W  flits remaining in the current packet
timeout_o  output  1  one-cycle pulse on a forced release (0 when the feature is compiled out)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: state=IDLE, owner=0, rr_ptr=NUM_PORTS-1 (so L has first priority), counter=0. All outputs are 0.
- Eligibility: input i is eligible iff req_i[i]=1 and flit_id slice i = FLIT_HEADER. Body or tail flits never win arbitration.
- IDLE state:
  - If any input is eligible, select the first one searching rr_ptr+1, rr_ptr+2, … modulo NUM_PORTS.
  - Register it as owner and load counter = length (a length of 0 is loaded as 1).
  - Move to ACTIVE. No grant is issued in IDLE, so the header is granted at the earliest one cycle after it is first eligible.
- ACTIVE state:
  - grant_o[owner] = req_i[owner] & out_ready_i, computed combinationally from the registered owner. All other grant bits are 0.
  - Each granted cycle decrements counter by 1.
  - When a grant occurs with counter==1: next state is IDLE, rr_ptr<=owner, counter<=0.
  - If out_ready_i=0 or req_i[owner]=0, hold the lock with no grant and no counter change. Other requesters are ignored.
- Headers from other inputs during ACTIVE wait; there is no preemption.
- Simultaneous packet end and new header: the new arbitration is decided in the following IDLE cycle. This gives one bubble cycle per packet, which is accepted.
- Tail-flit flit_id is not used for release; the counter alone is authoritative.
- busy_o=1 in ACTIVE. flits_left_o follows the counter.
- rst asserted mid-packet returns to the reset state on the next edge. Dropping the in-flight flits is acceptable.

Optional Feature:
WORMHOLE_TIMEOUT_EN
- When defined:
  - A stall counter counts consecutive ACTIVE cycles without a grant and is cleared on every grant.
  - When it reaches TIMEOUT, the scheduler pulses timeout_o for one cycle, returns to IDLE and sets rr_ptr<=owner.
- When undefined: there is no stall counter, the lock is held indefinitely, and timeout_o is tied to 0.

Decomposition:
- Flit-type constants (FLIT_HEADER=3'b001, FLIT_BODY=3'b010, FLIT_TAIL=3'b100), port indices and state encodings go in the shared parameters/state_defines include files.
- Natural sub-module: rr_pick5. It is combinational; inputs are the eligible vector and rr_ptr, outputs are a one-hot winner and a found flag. It is reused by any future allocator.

Test Plan:
- Reset, then L requests a header with length 3 and out_ready=1 -> grant_o=00001 on cycles 2, 3 and 4 after the request, busy_o deasserts after cycle 4, rr_ptr=0.
- L and E request headers (length 1) simultaneously and repeatedly -> grants alternate L, E, L, E with one idle cycle between packets.
- N locked with length 4; out_ready low for 3 cycles mid-packet -> no grant, flits_left_o holds at 2, completion resumes when out_ready rises, total grants = 4.
- N locked; S presents a header mid-packet -> S is granted only after N's 4th flit, never interleaved.
- Head flit is a body flit (flit_id=010) with no lock held -> no grant, busy_o stays 0.
- With WORMHOLE_TIMEOUT_EN and TIMEOUT=8, the owner stalls for 8 cycles -> timeout_o pulses, the port returns to IDLE and the next eligible header wins.
